// File: rtl/uart_param.sv
// Parametrised full-duplex UART: configurable data width and bit period, run-time
// parity (none/even/odd) and 1 or 2 stop bits, mid-bit sampling with false-start rejection.
module uart_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            parity_mode,
    input  logic                  two_stop,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_busy,
    output logic                  serial_out,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] received_data,
    output logic                  data_is_valid,
    output logic                  rx_error,
    output logic                  parity_error
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(9);
    localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);

    // ---------------------------------------------------------------- TX
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    tx_state_t             tx_state_reg, tx_state_next;
    logic [CW-1:0]         tx_cnt_reg, tx_cnt_next;
    logic [BW-1:0]         tx_bit_reg, tx_bit_next;
    logic [DATA_WIDTH-1:0] tx_shift_reg, tx_shift_next;
    logic                  tx_par_en_reg, tx_par_en_next;
    logic                  tx_par_bit_reg, tx_par_bit_next;
    logic                  tx_two_reg, tx_two_next;
    logic                  tx_line_reg, tx_line_next;
    logic                  tx_busy_reg, tx_busy_next;
    logic                  tx_tick, tx_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_reg   <= TX_IDLE;
            tx_cnt_reg     <= '0;
            tx_bit_reg     <= '0;
            tx_shift_reg   <= '0;
            tx_par_en_reg  <= 1'b0;
            tx_par_bit_reg <= 1'b0;
            tx_two_reg     <= 1'b0;
            tx_line_reg    <= 1'b1;
            tx_busy_reg    <= 1'b0;
        end else begin
            tx_state_reg   <= tx_state_next;
            tx_cnt_reg     <= tx_cnt_next;
            tx_bit_reg     <= tx_bit_next;
            tx_shift_reg   <= tx_shift_next;
            tx_par_en_reg  <= tx_par_en_next;
            tx_par_bit_reg <= tx_par_bit_next;
            tx_two_reg     <= tx_two_next;
            tx_line_reg    <= tx_line_next;
            tx_busy_reg    <= tx_busy_next;
        end
    end

    always_comb begin
        tx_tick         = (tx_cnt_reg == BIT_END);
        tx_load         = 1'b0;
        tx_state_next   = tx_state_reg;
        tx_cnt_next     = tx_tick ? '0 : tx_cnt_reg + 1'b1;
        tx_bit_next     = tx_bit_reg;
        tx_shift_next   = tx_shift_reg;
        tx_par_en_next  = tx_par_en_reg;
        tx_par_bit_next = tx_par_bit_reg;
        tx_two_next     = tx_two_reg;
        tx_line_next    = tx_line_reg;
        case (tx_state_reg)
            TX_IDLE: begin
                tx_cnt_next  = '0;
                tx_line_next = 1'b1;
                tx_load      = enable;
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_state_next = TX_DATA;
                    tx_line_next  = tx_shift_reg[0];
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_shift_next = tx_shift_reg >> 1;
                    if (tx_bit_reg == LAST_DATA) begin
                        tx_bit_next = '0;
                        if (tx_par_en_reg) begin
                            tx_state_next = TX_PARITY;
                            tx_line_next  = tx_par_bit_reg;
                        end else begin
                            tx_state_next = TX_STOP;
                            tx_line_next  = 1'b1;
                        end
                    end else begin
                        tx_bit_next  = tx_bit_reg + 1'b1;
                        tx_line_next = tx_shift_reg[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_tick) begin
                    tx_state_next = TX_STOP;
                    tx_line_next  = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    if (tx_two_reg && (tx_bit_reg == '0)) begin
                        tx_bit_next = 1'b1;
                    end else if (enable) begin
                        // Accepting on the last stop cycle keeps back-to-back frames gapless.
                        tx_load = 1'b1;
                    end else begin
                        tx_state_next = TX_IDLE;
                        tx_bit_next   = '0;
                        tx_line_next  = 1'b1;
                    end
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
        if (tx_load) begin
            tx_state_next   = TX_START;
            tx_cnt_next     = '0;
            tx_bit_next     = '0;
            tx_shift_next   = i_data;
            tx_par_en_next  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
            tx_par_bit_next = (^i_data) ^ (parity_mode == 2'b10);
            tx_two_next     = two_stop;
            tx_line_next    = 1'b0;
        end
        tx_busy_next = (tx_state_next != TX_IDLE);
    end

    assign serial_out = tx_line_reg;
    assign o_busy     = tx_busy_reg;

    // ---------------------------------------------------------------- RX
    typedef enum logic [2:0] {RX_IDLE, RX_START_CHK, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

    logic [1:0]            rx_sync_reg;
    logic                  rx_bit;
    rx_state_t             rx_state_reg, rx_state_next;
    logic [CW-1:0]         rx_cnt_reg, rx_cnt_next;
    logic [BW-1:0]         rx_bit_cnt_reg, rx_bit_cnt_next;
    logic [DATA_WIDTH-1:0] rx_shift_reg, rx_shift_next;
    logic [DATA_WIDTH-1:0] rx_data_reg, rx_data_next;
    logic                  rx_par_en_reg, rx_par_en_next;
    logic                  rx_odd_reg, rx_odd_next;
    logic                  rx_two_reg, rx_two_next;
    logic                  rx_par_fail_reg, rx_par_fail_next;
    logic                  rx_stop_fail_reg, rx_stop_fail_next;
    logic                  rx_valid_reg, rx_valid_next;
    logic                  rx_err_reg, rx_err_next;
    logic                  rx_perr_reg, rx_perr_next;
    logic                  rx_tick, rx_frame_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync_reg <= 2'b11;
        end else begin
            rx_sync_reg <= {rx_sync_reg[0], serial_in};
        end
    end

    assign rx_bit = rx_sync_reg[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_reg     <= RX_IDLE;
            rx_cnt_reg       <= '0;
            rx_bit_cnt_reg   <= '0;
            rx_shift_reg     <= '0;
            rx_data_reg      <= '0;
            rx_par_en_reg    <= 1'b0;
            rx_odd_reg       <= 1'b0;
            rx_two_reg       <= 1'b0;
            rx_par_fail_reg  <= 1'b0;
            rx_stop_fail_reg <= 1'b0;
            rx_valid_reg     <= 1'b0;
            rx_err_reg       <= 1'b0;
            rx_perr_reg      <= 1'b0;
        end else begin
            rx_state_reg     <= rx_state_next;
            rx_cnt_reg       <= rx_cnt_next;
            rx_bit_cnt_reg   <= rx_bit_cnt_next;
            rx_shift_reg     <= rx_shift_next;
            rx_data_reg      <= rx_data_next;
            rx_par_en_reg    <= rx_par_en_next;
            rx_odd_reg       <= rx_odd_next;
            rx_two_reg       <= rx_two_next;
            rx_par_fail_reg  <= rx_par_fail_next;
            rx_stop_fail_reg <= rx_stop_fail_next;
            rx_valid_reg     <= rx_valid_next;
            rx_err_reg       <= rx_err_next;
            rx_perr_reg      <= rx_perr_next;
        end
    end

    always_comb begin
        rx_tick           = (rx_cnt_reg == BIT_END);
        rx_frame_bad      = rx_stop_fail_reg | ~rx_bit;
        rx_state_next     = rx_state_reg;
        rx_cnt_next       = rx_tick ? '0 : rx_cnt_reg + 1'b1;
        rx_bit_cnt_next   = rx_bit_cnt_reg;
        rx_shift_next     = rx_shift_reg;
        rx_data_next      = rx_data_reg;
        rx_par_en_next    = rx_par_en_reg;
        rx_odd_next       = rx_odd_reg;
        rx_two_next       = rx_two_reg;
        rx_par_fail_next  = rx_par_fail_reg;
        rx_stop_fail_next = rx_stop_fail_reg;
        rx_valid_next     = 1'b0;
        rx_err_next       = 1'b0;
        rx_perr_next      = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                rx_cnt_next = '0;
                if (!rx_bit) begin
                    rx_state_next     = RX_START_CHK;
                    rx_bit_cnt_next   = '0;
                    rx_par_en_next    = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    rx_odd_next       = (parity_mode == 2'b10);
                    rx_two_next       = two_stop;
                    rx_par_fail_next  = 1'b0;
                    rx_stop_fail_next = 1'b0;
                end
            end
            RX_START_CHK: begin
                if (rx_cnt_reg == HALF_END) begin
                    rx_cnt_next   = '0;
                    rx_state_next = rx_bit ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_shift_next = {rx_bit, rx_shift_reg[DATA_WIDTH-1:1]};
                    if (rx_bit_cnt_reg == LAST_DATA) begin
                        rx_bit_cnt_next = '0;
                        rx_state_next   = rx_par_en_reg ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_cnt_next = rx_bit_cnt_reg + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_tick) begin
                    rx_par_fail_next = rx_bit != ((^rx_shift_reg) ^ rx_odd_reg);
                    rx_state_next    = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    if (rx_two_reg && (rx_bit_cnt_reg == '0)) begin
                        rx_bit_cnt_next   = 1'b1;
                        rx_stop_fail_next = rx_stop_fail_reg | ~rx_bit;
                    end else begin
                        // Final stop sample: report, then park in BREAK while the line is held low.
                        rx_bit_cnt_next = '0;
                        if (!rx_frame_bad && !rx_par_fail_reg) begin
                            rx_valid_next = 1'b1;
                            rx_data_next  = rx_shift_reg;
                        end else begin
                            rx_err_next  = 1'b1;
                            rx_perr_next = rx_par_fail_reg & ~rx_frame_bad;
                        end
                        rx_state_next = rx_bit ? RX_IDLE : RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                rx_cnt_next = '0;
                if (rx_bit) begin
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    assign received_data = rx_data_reg;
    assign data_is_valid = rx_valid_reg;
    assign rx_error      = rx_err_reg;
    assign parity_error  = rx_perr_reg;

endmodule

// File: tb/tb_uart_param.sv
// Self-checking bench for uart_param: per-cycle comparison against a frame-level
// reference model (expected line waveform queue plus expected RX event scoreboard).
module tb_uart_param;

    localparam int DW   = 8;
    localparam int CPB  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    parity_mode = 2'b00;
    logic          two_stop = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          o_busy, serial_out, serial_in;
    logic [DW-1:0] received_data;
    logic          data_is_valid, rx_error, parity_error;
    logic          loopback = 1'b0;
    logic          line_drv = 1'b1;

    assign serial_in = loopback ? serial_out : line_drv;

    always #5 clk = ~clk;

    uart_param #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .parity_mode   (parity_mode),
        .two_stop      (two_stop),
        .enable        (enable),
        .i_data        (i_data),
        .o_busy        (o_busy),
        .serial_out    (serial_out),
        .serial_in     (serial_in),
        .received_data (received_data),
        .data_is_valid (data_is_valid),
        .rx_error      (rx_error),
        .parity_error  (parity_error)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model: frames as bit vectors
    function automatic bit has_parity(input logic [1:0] pm);
        return (pm == 2'b01) || (pm == 2'b10);
    endfunction

    function automatic int frame_len(input logic [1:0] pm, input logic ts);
        return 1 + DW + (has_parity(pm) ? 1 : 0) + (ts ? 2 : 1);
    endfunction

    // bit 0 is the start bit; unused upper bits stay 1 (idle)
    function automatic logic [15:0] build_frame(input logic [DW-1:0] d, input logic [1:0] pm,
                                                input logic ts, input bit bad_par, input bit stop_low);
        logic [15:0] v;
        int k;
        v = '1;
        v[0] = 1'b0;
        for (int i = 0; i < DW; i++) v[1+i] = d[i];
        k = 1 + DW;
        if (has_parity(pm)) begin
            v[k] = ((($countones(d) % 2) == 1) ? 1'b1 : 1'b0) ^ (pm == 2'b10) ^ bad_par;
            k++;
        end
        v[k] = 1'b1;
        k++;
        if (ts) begin
            v[k] = 1'b1;
            k++;
        end
        if (stop_low) v[k-1] = 1'b0;
        return v;
    endfunction

    typedef struct {
        bit            is_err;
        bit            pe;
        logic [DW-1:0] data;
        int            lo;
        int            hi;
    } ev_t;

    ev_t           ev_q[$];
    bit            tx_q[$];
    bit            exp_line = 1'b1;
    bit            exp_busy = 1'b0;
    int            tx_accepts = 0;
    int            last_accept_cyc = 0;
    int            tx_n;
    logic [15:0]   tx_v;
    ev_t           tx_ev;

    // TX model: a frame becomes a per-cycle list of line levels; a new request is
    // taken only when the list of the previous frame is exhausted.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            tx_q.delete();
            exp_line = 1'b1;
            exp_busy = 1'b0;
        end else if (tx_q.size() > 0) begin
            exp_line = tx_q.pop_front();
            exp_busy = 1'b1;
        end else if (enable) begin
            tx_n = frame_len(parity_mode, two_stop);
            tx_v = build_frame(i_data, parity_mode, two_stop, 1'b0, 1'b0);
            for (int b = 0; b < tx_n; b++)
                for (int c = 0; c < CPB; c++) tx_q.push_back(tx_v[b]);
            exp_line = tx_q.pop_front();
            exp_busy = 1'b1;
            tx_accepts++;
            last_accept_cyc = cyc;
            if (loopback) begin
                tx_ev.is_err = 1'b0;
                tx_ev.pe     = 1'b0;
                tx_ev.data   = i_data;
                tx_ev.lo     = cyc + (tx_n - 1) * CPB;
                tx_ev.hi     = cyc + tx_n * CPB;
                ev_q.push_back(tx_ev);
            end
        end else begin
            exp_line = 1'b1;
            exp_busy = 1'b0;
        end
    end

    // ---------------- compare process
    logic [DW-1:0] model_rx = '0;
    int            dv_count = 0;
    int            err_count = 0;
    int            pe_count = 0;
    int            busy_run = 0;
    int            last_busy_len = 0;
    ev_t           ce;

    always @(negedge clk) begin
        if (!rst_n) begin
            ev_q.delete();
            model_rx = '0;
            busy_run = 0;
            chk("reset_serial_out", serial_out, 1);
            chk("reset_o_busy", o_busy, 0);
            chk("reset_received_data", received_data, 0);
            chk("reset_pulses", {data_is_valid, rx_error, parity_error}, 0);
        end else begin
            chk("serial_out", serial_out, exp_line);
            chk("o_busy", o_busy, exp_busy);
            chk("valid_error_exclusive", data_is_valid & rx_error, 0);
            if (!rx_error) chk("parity_error_without_rx_error", parity_error, 0);
            if (o_busy) busy_run++;
            else if (busy_run != 0) begin
                last_busy_len = busy_run;
                busy_run = 0;
            end
            if (data_is_valid || rx_error) begin
                if (data_is_valid) dv_count++;
                if (rx_error) err_count++;
                if (rx_error && parity_error) pe_count++;
                if (ev_q.size() == 0) begin
                    chk("unexpected_rx_pulse", {data_is_valid, rx_error}, 0);
                end else begin
                    ce = ev_q.pop_front();
                    chk("rx_pulse_kind_is_error", rx_error, ce.is_err);
                    chk("rx_pulse_in_final_stop_bit", (cyc >= ce.lo && cyc < ce.hi), 1);
                    if (ce.is_err) begin
                        chk("parity_error_flag", parity_error, ce.pe);
                        chk("received_data_kept_on_error", received_data, model_rx);
                    end else begin
                        chk("received_data_on_valid", received_data, ce.data);
                        model_rx = ce.data;
                    end
                end
            end else begin
                chk("received_data_hold", received_data, model_rx);
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tx_idle(input int budget);
        int k;
        k = 0;
        while (exp_busy && k < budget) begin
            tick(1);
            k++;
        end
        chk("tx_idle_within_budget", (k < budget), 1);
    endtask

    task automatic wait_rx_drained(input int budget);
        int k;
        k = 0;
        while (ev_q.size() > 0 && k < budget) begin
            tick(1);
            k++;
        end
        chk("rx_expected_events_seen", ev_q.size(), 0);
    endtask

    task automatic send_tx(input logic [DW-1:0] d);
        enable = 1'b1;
        i_data = d;
        tick(1);
        enable = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input bit bad_par, input bit stop_low, input int hold_low);
        int n;
        logic [15:0] v;
        ev_t e;
        n = frame_len(parity_mode, two_stop);
        v = build_frame(d, parity_mode, two_stop, bad_par, stop_low);
        e.data   = d;
        e.is_err = stop_low || (bad_par && has_parity(parity_mode));
        e.pe     = !stop_low && bad_par && has_parity(parity_mode);
        tick(1);
        e.lo = cyc + (n - 1) * CPB;
        e.hi = cyc + n * CPB;
        ev_q.push_back(e);
        for (int b = 0; b < n; b++) begin
            line_drv = v[b];
            tick(CPB);
        end
        if (hold_low > 0) tick(hold_low);
        line_drv = 1'b1;
    endtask

    task automatic glitch(input int len);
        tick(1);
        line_drv = 1'b0;
        tick(len);
        line_drv = 1'b1;
    endtask

    // ---------------- main sequence
    int d0, e0, p0, a0, first_acc, k;
    logic [15:0] pin_v;

    initial begin
        tick(4);
        rst_n = 1'b1;
        tick(2);

        // model pins: 0x07 even parity -> parity bit 1; 0xFF odd parity -> parity bit 1
        pin_v = build_frame(8'h07, 2'b01, 1'b0, 1'b0, 1'b0);
        chk("model_frame_07_even", pin_v[10:0], 11'h60E);
        pin_v = build_frame(8'hFF, 2'b10, 1'b0, 1'b0, 1'b0);
        chk("model_frame_ff_odd", pin_v[10:0], 11'h7FE);

        // loopback 8N1 0xA5
        loopback = 1'b1;
        d0 = dv_count;
        send_tx(8'hA5);
        wait_tx_idle(400);
        wait_rx_drained(100);
        tick(2);
        chk("busy_cycles_8n1", last_busy_len, 160);
        chk("loopback_rx_a5", received_data, 8'hA5);
        chk("loopback_valid_pulses", dv_count - d0, 1);
        $display("txn loopback 0xA5 rx=0x%0h busy=%0d", received_data, last_busy_len);

        // even parity with parity bit forced low
        loopback = 1'b0;
        parity_mode = 2'b01;
        e0 = err_count; p0 = pe_count;
        send_frame(8'h07, 1'b1, 1'b0, 0);
        wait_rx_drained(50);
        chk("parity_err_pulses", err_count - e0, 1);
        chk("parity_err_flag_pulses", pe_count - p0, 1);
        chk("parity_err_data_unchanged", received_data, 8'hA5);
        $display("txn parity-error 0x07 rx=0x%0h", received_data);

        // two stop bits, second stop low, line held low (break), then 0x3C
        parity_mode = 2'b00;
        two_stop = 1'b1;
        e0 = err_count; p0 = pe_count;
        send_frame(8'hC3, 1'b0, 1'b1, 250);
        tick(20);
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        wait_rx_drained(50);
        chk("framing_err_pulses", err_count - e0, 1);
        chk("framing_err_not_parity", pe_count - p0, 0);
        chk("after_break_rx_3c", received_data, 8'h3C);
        $display("txn break-then-0x3C rx=0x%0h", received_data);

        // glitch of 5 cycles, then 0x5A
        two_stop = 1'b0;
        d0 = dv_count; e0 = err_count;
        glitch(5);
        tick(40);
        chk("glitch_no_pulse", (dv_count - d0) + (err_count - e0), 0);
        send_frame(8'h5A, 1'b0, 1'b0, 0);
        wait_rx_drained(50);
        chk("after_glitch_rx_5a", received_data, 8'h5A);
        $display("txn glitch-then-0x5A rx=0x%0h", received_data);

        // back-to-back with enable held, plus an ignored request mid-frame
        loopback = 1'b1;
        d0 = dv_count;
        a0 = tx_accepts;
        enable = 1'b1;
        i_data = 8'h11;
        k = 0;
        while (tx_accepts < a0 + 1 && k < 50) begin tick(1); k++; end
        first_acc = last_accept_cyc;
        i_data = 8'h22;
        k = 0;
        while (tx_accepts < a0 + 2 && k < 400) begin tick(1); k++; end
        enable = 1'b0;
        chk("b2b_start_gap", last_accept_cyc - first_acc, 160);
        tick(30);
        send_tx(8'h99);
        wait_tx_idle(400);
        wait_rx_drained(100);
        chk("b2b_rx_last", received_data, 8'h22);
        chk("b2b_valid_pulses", dv_count - d0, 2);
        $display("txn back-to-back 0x11,0x22 rx=0x%0h", received_data);

        // reset mid-frame on TX and RX, then odd-parity 0xFF
        parity_mode = 2'b10;
        d0 = dv_count; e0 = err_count;
        send_tx(8'h55);
        tick(60);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        chk("reset_no_pulses", (dv_count - d0) + (err_count - e0), 0);
        send_tx(8'hFF);
        wait_tx_idle(400);
        wait_rx_drained(100);
        chk("after_reset_rx_ff", received_data, 8'hFF);
        $display("txn reset-then-0xFF odd rx=0x%0h", received_data);

        // randomized concurrent TX and RX traffic
        loopback = 1'b0;
        tick(5);
        for (int it = 0; it < 24; it++) begin
            logic [DW-1:0] td, rd;
            int choice;
            parity_mode = 2'($urandom_range(0, 3));
            two_stop = 1'($urandom_range(0, 1));
            td = DW'($urandom);
            rd = DW'($urandom);
            choice = $urandom_range(0, 5);
            fork
                begin
                    send_tx(td);
                    if ($urandom_range(0, 1) == 1) begin
                        tick($urandom_range(10, 100));
                        send_tx(DW'($urandom));
                    end
                    wait_tx_idle(800);
                end
                begin
                    tick($urandom_range(0, 20));
                    if (choice == 0) begin
                        glitch($urandom_range(1, 6));
                        tick(20);
                        send_frame(rd, 1'b0, 1'b0, 0);
                    end else if (choice == 1) begin
                        send_frame(rd, 1'b1, 1'b0, 0);
                    end else if (choice == 2) begin
                        send_frame(rd, 1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 30));
                    end else begin
                        send_frame(rd, 1'b0, 1'b0, 0);
                    end
                    wait_rx_drained(300);
                end
            join
            $display("txn random %0d mode=%0d two_stop=%0d tx=0x%0h rx_sent=0x%0h kind=%0d rx=0x%0h",
                     it, parity_mode, two_stop, td, rd, choice, received_data);
            tick(3);
        end

        tick(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        chk("watchdog_timeout", 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
